// File: rtl/lockstep_pkg.sv
// lockstep_pkg: shared types and defaults for the lockstep recovery controller
package lockstep_pkg;
    localparam int unsigned BUS_W            = 32;
    localparam int unsigned DRAIN_CYCLES_DEF = 2;
    localparam int unsigned MAX_ERRORS_DEF   = 10;
    typedef enum logic [2:0] {
        REC_RUN,
        REC_ERROR,
        REC_DRAIN,
        REC_RESTORE,
        REC_RESUME,
        REC_FATAL
    } rec_state_e;
    typedef struct packed {
        logic             instr_req;
        logic [BUS_W-1:0] instr_addr;
        logic             data_req;
        logic             data_we;
        logic [BUS_W-1:0] data_addr;
        logic [BUS_W-1:0] data_wdata;
    } core_bus_t;
endpackage

// File: rtl/lockstep_cmp.sv
// lockstep_cmp: combinational divergence check between two core bus bundles
//   a_i, b_i    : bus bundles of core 0 and core 1
//   mismatch_o  : high when the visible bus behaviour differs
module lockstep_cmp
    import lockstep_pkg::*;
(
    input  core_bus_t a_i,
    input  core_bus_t b_i,
    output logic      mismatch_o
);
    logic both_i, both_d;
    assign both_i = a_i.instr_req & b_i.instr_req;
    assign both_d = a_i.data_req & b_i.data_req;
    // Address/data fields only matter when the qualifying request (and write) is active on both sides.
    assign mismatch_o = (a_i.instr_req != b_i.instr_req)
                      | (both_i & (a_i.instr_addr != b_i.instr_addr))
                      | (a_i.data_req != b_i.data_req)
                      | (both_d & ((a_i.data_we != b_i.data_we) | (a_i.data_addr != b_i.data_addr)))
                      | (both_d & a_i.data_we & b_i.data_we & (a_i.data_wdata != b_i.data_wdata));
endmodule

// File: rtl/lockstep_recovery_ctrl.sv
// lockstep_recovery_ctrl: detects lockstep divergence, halts both cores, copies core 0's RF into core 1 and restores its PC
//   c0_*/c1_*        : core bus outputs under comparison, c0_pc_i is core 0's ID-stage PC
//   rf_raddr_o/rdata : asynchronous read port of core 0's register file
//   rf_we/waddr/wdata: write port of core 1's register file
//   pc_restore*      : PC load for core 1, halt_o stalls both cores
//   error_o/err_count_o/fatal_o/recovering_o : status
module lockstep_recovery_ctrl
    import lockstep_pkg::*;
#(
    parameter int unsigned DATA_W       = BUS_W,
    parameter int unsigned RF_ADDR_W    = 5,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MAX_ERRORS   = MAX_ERRORS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 c0_instr_req_i,
    input  logic                 c1_instr_req_i,
    input  logic [DATA_W-1:0]    c0_instr_addr_i,
    input  logic [DATA_W-1:0]    c1_instr_addr_i,
    input  logic                 c0_data_req_i,
    input  logic                 c1_data_req_i,
    input  logic                 c0_data_we_i,
    input  logic                 c1_data_we_i,
    input  logic [DATA_W-1:0]    c0_data_addr_i,
    input  logic [DATA_W-1:0]    c1_data_addr_i,
    input  logic [DATA_W-1:0]    c0_data_wdata_i,
    input  logic [DATA_W-1:0]    c1_data_wdata_i,
    input  logic [DATA_W-1:0]    c0_pc_i,
    output logic [RF_ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0]    rf_rdata_i,
    output logic                 rf_we_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0]    rf_wdata_o,
    output logic [DATA_W-1:0]    pc_restore_o,
    output logic                 pc_restore_valid_o,
    output logic                 halt_o,
    output logic                 error_o,
    output logic                 recovering_o,
    output logic [CNT_W-1:0]     err_count_o,
    output logic                 fatal_o
);
    localparam int unsigned DC_W = $clog2(DRAIN_CYCLES + 1);
    rec_state_e          st_q;
    logic [DC_W-1:0]     drain_q;
    logic [RF_ADDR_W-1:0] idx_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   pc_q;
    logic                error_q;
    logic                mismatch;
    core_bus_t           c0_bus, c1_bus;

    assign c0_bus = '{instr_req: c0_instr_req_i, instr_addr: c0_instr_addr_i, data_req: c0_data_req_i,
                      data_we: c0_data_we_i, data_addr: c0_data_addr_i, data_wdata: c0_data_wdata_i};
    assign c1_bus = '{instr_req: c1_instr_req_i, instr_addr: c1_instr_addr_i, data_req: c1_data_req_i,
                      data_we: c1_data_we_i, data_addr: c1_data_addr_i, data_wdata: c1_data_wdata_i};

    lockstep_cmp u_cmp (
        .a_i        (c0_bus),
        .b_i        (c1_bus),
        .mismatch_o (mismatch)
    );

    assign cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= REC_RUN;
            drain_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            error_q <= 1'b0;
        end else begin
            case (st_q)
                REC_RUN: if (enable_i && mismatch) begin
                    pc_q    <= c0_pc_i;
                    cnt_q   <= cnt_d;
                    error_q <= 1'b1;
                    st_q    <= (cnt_d >= CNT_W'(MAX_ERRORS)) ? REC_FATAL : REC_ERROR;
                end
                REC_ERROR: begin
                    error_q <= 1'b0;
                    drain_q <= DC_W'(DRAIN_CYCLES);
                    st_q    <= REC_DRAIN;
                end
                REC_DRAIN: if (drain_q == DC_W'(1)) begin
                    idx_q <= RF_ADDR_W'(1);
                    st_q  <= REC_RESTORE;
                end else begin
                    drain_q <= drain_q - 1'b1;
                end
                // The index wraps back to 0 after the last register, so it idles at 0 outside RESTORE.
                REC_RESTORE: begin
                    idx_q <= idx_q + 1'b1;
                    if (&idx_q) st_q <= REC_RESUME;
                end
                REC_RESUME: st_q <= REC_RUN;
                REC_FATAL: error_q <= 1'b0;
                default: st_q <= REC_RUN;
            endcase
        end
    end

    assign recovering_o       = st_q != REC_RUN;
    assign halt_o             = recovering_o;
    assign rf_we_o            = st_q == REC_RESTORE;
    assign rf_raddr_o         = idx_q;
    assign rf_waddr_o         = idx_q;
    assign rf_wdata_o         = rf_we_o ? rf_rdata_i : '0;
    assign pc_restore_o       = pc_q;
    assign pc_restore_valid_o = st_q == REC_RESUME;
    assign error_o            = error_q;
    assign err_count_o        = cnt_q;
    assign fatal_o            = st_q == REC_FATAL;
endmodule

// File: tb/tb_lockstep_recovery_ctrl.sv
// tb_lockstep_recovery_ctrl: randomized and directed check of lockstep_recovery_ctrl against a phase-offset reference model
module tb_lockstep_recovery_ctrl;
    localparam int D = 2, NR = 31, TOTAL = D + NR + 2, MAXE = 10;

    logic clk = 1'b0, rst_ni = 1'b1, en;
    logic c0_ir, c1_ir, c0_dr, c1_dr, c0_dw, c1_dw;
    logic [31:0] c0_ia, c1_ia, c0_da, c1_da, c0_dd, c1_dd, c0_pc;
    logic [4:0] rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata, pc_restore;
    logic rf_we, pc_valid, halt, error, recovering, fatal;
    logic [7:0] err_count;
    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];

    int n_cmp = 0, n_bad = 0;
    int m_pos, m_cnt;
    bit m_fatal, m_first;
    logic [31:0] m_pc;
    logic [31:0] iaddr = 0;

    always #5 clk = ~clk;
    assign rf_rdata = rf0[rf_raddr];
    always @(posedge clk) if (rf_we) rf1[rf_waddr] <= rf_wdata;

    lockstep_recovery_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(en),
        .c0_instr_req_i(c0_ir), .c1_instr_req_i(c1_ir),
        .c0_instr_addr_i(c0_ia), .c1_instr_addr_i(c1_ia),
        .c0_data_req_i(c0_dr), .c1_data_req_i(c1_dr),
        .c0_data_we_i(c0_dw), .c1_data_we_i(c1_dw),
        .c0_data_addr_i(c0_da), .c1_data_addr_i(c1_da),
        .c0_data_wdata_i(c0_dd), .c1_data_wdata_i(c1_dd),
        .c0_pc_i(c0_pc),
        .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pc_restore_o(pc_restore), .pc_restore_valid_o(pc_valid),
        .halt_o(halt), .error_o(error), .recovering_o(recovering),
        .err_count_o(err_count), .fatal_o(fatal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // What each core exposes to memory; cores diverge when these views differ.
    function automatic bit differ();
        logic [32:0] i0, i1;
        logic [65:0] d0, d1;
        i0 = c0_ir ? {1'b1, c0_ia} : '0;
        i1 = c1_ir ? {1'b1, c1_ia} : '0;
        d0 = c0_dr ? {1'b1, c0_dw, c0_da, c0_dw ? c0_dd : 32'h0} : '0;
        d1 = c1_dr ? {1'b1, c1_dw, c1_da, c1_dw ? c1_dd : 32'h0} : '0;
        return (i0 != i1) || (d0 != d1);
    endfunction

    // m_pos counts cycles since the error pulse: 0 error, 1..D drain, D+1..D+NR restore, last resume.
    task automatic model_edge();
        if (m_fatal) m_first = 0;
        else if (m_pos >= 0) m_pos = (m_pos == TOTAL - 1) ? -1 : m_pos + 1;
        else if (en && differ()) begin
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_pc = c0_pc;
            if (m_cnt >= MAXE) begin
                m_fatal = 1;
                m_first = 1;
            end else m_pos = 0;
        end
    endtask

    task automatic check_all();
        bit run, we;
        int idx;
        run = !m_fatal && m_pos < 0;
        we = !m_fatal && m_pos > D && m_pos <= D + NR;
        idx = we ? m_pos - D : 0;
        chk("halt", halt, !run);
        chk("recovering", recovering, !run);
        chk("error", error, m_pos == 0 || m_first);
        chk("rf_we", rf_we, we);
        chk("rf_waddr", rf_waddr, idx);
        chk("rf_raddr", rf_raddr, idx);
        chk("rf_wdata", rf_wdata, we ? 32'h1000 + idx : 0);
        chk("pc_valid", pc_valid, m_pos == D + NR + 1);
        chk("pc_restore", pc_restore, m_pc);
        chk("err_count", err_count, m_cnt);
        chk("fatal", fatal, m_fatal);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        en = 1;
        c0_ir = 1; c1_ir = 1; c0_ia = iaddr; c1_ia = iaddr;
        c0_dr = 0; c1_dr = 0; c0_dw = 0; c1_dw = 0;
        c0_da = 0; c1_da = 0; c0_dd = 0; c1_dd = 0;
        c0_pc = iaddr;
        iaddr = (iaddr + 4) & 32'hFC;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_idle();
            cycle();
        end
    endtask

    // kind 0 identical, 1..6 divergent, 7..9 differences the comparison must ignore
    task automatic gen(input int kind);
        c0_ir = 1'($urandom); c0_ia = $urandom; c0_dr = 1'($urandom); c0_dw = 1'($urandom);
        c0_da = $urandom; c0_dd = $urandom; c0_pc = $urandom;
        if (kind inside {1}) c0_ir = 1;
        if (kind inside {4, 5, 6, 7}) c0_dr = 1;
        if (kind == 6) c0_dw = 1;
        if (kind == 7) c0_dw = 0;
        if (kind == 8) c0_ir = 0;
        if (kind == 9) c0_dr = 0;
        c1_ir = c0_ir; c1_ia = c0_ia; c1_dr = c0_dr; c1_dw = c0_dw; c1_da = c0_da; c1_dd = c0_dd;
        case (kind)
            1: c1_ia = c0_ia ^ (32'h1 << $urandom_range(0, 31));
            2: c1_ir = ~c0_ir;
            3: c1_dr = ~c0_dr;
            4: c1_dw = ~c0_dw;
            5: c1_da = c0_da ^ (32'h1 << $urandom_range(0, 31));
            6, 7: c1_dd = ~c0_dd;
            8: c1_ia = ~c0_ia;
            9: begin c1_da = ~c0_da; c1_dd = ~c0_dd; c1_dw = ~c0_dw; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst_ni = 0;
        #1;
        chk("rst_halt", halt, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_error", error, 0);
        chk("rst_fatal", fatal, 0);
        chk("rst_pc", pc_restore, 0);
        chk("rst_pcv", pc_valid, 0);
        m_pos = -1; m_cnt = 0; m_fatal = 0; m_first = 0; m_pc = 0;
        set_idle();
        @(posedge clk);
        #3;
        rst_ni = 1;
    endtask

    task automatic inject_instr();
        set_idle();
        c0_ia = 32'h40; c1_ia = 32'h44; c0_pc = 32'h3C;
        cycle();
    endtask

    initial begin
        int halts;
        for (int i = 0; i < 32; i++) rf0[i] = 32'h1000 + i;
        set_idle();
        #2;
        do_reset();
        idle(500);
        // single instruction-address divergence and full recovery
        halts = 0;
        inject_instr();
        if (halt) halts++;
        for (int k = 0; k < 40; k++) begin
            set_idle();
            cycle();
            if (halt) halts++;
        end
        chk("halt_len", halts, 35);
        chk("pc_after", pc_restore, 32'h3C);
        chk("cnt_after", err_count, 1);
        for (int i = 1; i < 32; i++) chk("rf_copy", rf1[i], 32'h1000 + i);
        // write data ignored unless both cores write
        do_reset();
        gen(7); c0_dd = 32'hAAAA; c1_dd = 32'h5555; en = 1;
        cycle();
        idle(2);
        chk("we0_no_err", err_count, 0);
        gen(6); c0_dd = 32'hAAAA; c1_dd = 32'h5555; en = 1;
        cycle();
        chk("we1_err", error, 1);
        idle(40);
        // divergence during restore is ignored
        do_reset();
        inject_instr();
        for (int k = 0; k < 60 && m_pos != D + 10; k++) begin
            set_idle();
            cycle();
        end
        chk("reach_idx10", rf_waddr, 10);
        gen(1); cycle();
        idle(40);
        chk("cnt_restore_inj", err_count, 1);
        // tenth error is fatal
        do_reset();
        for (int e = 0; e < MAXE; e++) begin
            inject_instr();
            if (e < MAXE - 1) idle(36);
        end
        chk("fatal_entry_err", error, 1);
        idle(30);
        chk("fatal_held", fatal, 1);
        chk("fatal_halt", halt, 1);
        // reset in the middle of restore
        do_reset();
        inject_instr();
        for (int k = 0; k < 60 && m_pos != D + 5; k++) begin
            set_idle();
            cycle();
        end
        chk("reach_idx5", rf_waddr, 5);
        do_reset();
        idle(50);
        // random traffic
        for (int k = 0; k < 4000; k++) begin
            gen(($urandom_range(0, 99) < 5) ? $urandom_range(1, 9) : 0);
            en = ($urandom_range(0, 9) != 0);
            cycle();
            if ((m_fatal && $urandom_range(0, 19) == 0) || $urandom_range(0, 499) == 0) do_reset();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lockstep_recovery_ctrl.md
Name: lockstep_recovery_ctrl

Overview:
- Responder side of the fault-injection flow: compares the bus outputs of the two lockstep cores every cycle.
- On divergence it:
  - flags the error;
  - halts both cores;
  - copies the architectural register file from core 0 into core 1;
  - restores core 1's PC;
  - resumes execution.
- Sits inside the fault-tolerant core wrapper, between core_0/core_1 and the shared instruction/data memories.

Parameters:
- DATA_W, 32, width of addresses, data and register values.
- RF_ADDR_W, 5, register-file address width; x1..x(2^RF_ADDR_W-1) are restored.
- DRAIN_CYCLES, 2, halt cycles before the restore starts; must be >= 1.
- CNT_W, 8, width of the error counter.
- MAX_ERRORS, 10, detected-error count that forces the FATAL state; must be <= 2^CNT_W-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  comparison enable
- c0_instr_req_i / c1_instr_req_i  in  1  instruction request, core 0 / core 1
- c0_instr_addr_i / c1_instr_addr_i  in  DATA_W  instruction address
- c0_data_req_i / c1_data_req_i  in  1  data request
- c0_data_we_i / c1_data_we_i  in  1  data write enable
- c0_data_addr_i / c1_data_addr_i  in  DATA_W  data address
- c0_data_wdata_i / c1_data_wdata_i  in  DATA_W  data write data
- c0_pc_i  in  DATA_W  core 0 ID-stage PC
- rf_raddr_o  out  RF_ADDR_W  core 0 register-file read address (asynchronous read)
- rf_rdata_i  in  DATA_W  core 0 register-file read data
- rf_we_o  out  1  core 1 register-file write enable
- rf_waddr_o  out  RF_ADDR_W  core 1 register-file write address
- rf_wdata_o  out  DATA_W  core 1 register-file write data
- pc_restore_o  out  DATA_W  PC to load into core 1
- pc_restore_valid_o  out  1  one-cycle PC load strobe
- halt_o  out  1  stall both cores
- error_o  out  1  one-cycle pulse per detected error
- recovering_o  out  1  high while not in RUN
- err_count_o  out  CNT_W  detected-error count
- fatal_o  out  1  unrecoverable; held until reset

Behaviour:
- Reset: every output is 0, state = RUN, counter = 0.
- Mismatch (combinational, evaluated only in RUN with enable_i = 1) is true if any of the following holds:
  - instr_req differs between cores;
  - both instr_req high and instr_addr differs;
  - data_req differs;
  - both data_req high and data_we or data_addr differs;
  - both data_req high, both data_we high, and data_wdata differs.
- States: RUN, ERROR, DRAIN, RESTORE, RESUME, FATAL.
- RUN:
  - Mismatch at a rising edge: latch c0_pc_i into pc_restore_o, counter += 1 (saturating).
  - Next state is FATAL if the new count >= MAX_ERRORS, else ERROR.
- ERROR: error_o = 1 and halt_o = 1 for exactly one cycle, then DRAIN.
- DRAIN:
  - halt_o = 1; a down-counter loads DRAIN_CYCLES on entry.
  - Leave to RESTORE when the counter reaches 1, so DRAIN lasts exactly DRAIN_CYCLES cycles.
- RESTORE:
  - halt_o = 1; index i runs 1..2^RF_ADDR_W-1, one register per cycle.
  - rf_raddr_o = rf_waddr_o = i, rf_wdata_o = rf_rdata_i, rf_we_o = 1.
  - x0 is never written. After the last index, go to RESUME (31 cycles for the defaults).
- RESUME: halt_o = 1 and pc_restore_valid_o = 1 for one cycle, then RUN. halt_o drops in the first RUN cycle.
- FATAL:
  - error_o pulses for one cycle on entry; halt_o = 1 and fatal_o = 1 permanently.
  - Exit only through reset.
- recovering_o = 1 in every state except RUN.
- Comparison is blocked outside RUN: mismatches during ERROR/DRAIN/RESTORE/RESUME are ignored and not counted.
- enable_i = 0: remain in RUN, no detection, counter frozen. enable_i has no effect on a recovery already in progress.
- Counter saturates at 2^CNT_W-1 and never wraps; err_count_o is the counter register.
- Reset asserted mid-recovery:
  - all outputs are 0 immediately (asynchronous); the restore index is not preserved.
  - rf_we_o deasserts without any further write.
- rf_raddr_o, rf_waddr_o and rf_wdata_o are 0 whenever rf_we_o = 0.

Decomposition:
- Package lockstep_pkg holds:
  - the state enum type rec_state_e;
  - the default constants for DRAIN_CYCLES and MAX_ERRORS;
  - a packed struct core_bus_t (instr_req, instr_addr, data_req, data_we, data_addr, data_wdata) for the per-core compare bundle.
- One sub-module: lockstep_cmp, the combinational mismatch function of two core_bus_t.
- The FSM, counters and restore index stay in lockstep_recovery_ctrl.

Test Plan:
- Identical streams on both cores (instr_addr 0x00..0xFC, no data traffic) for 500 cycles -> error_o never high, err_count_o = 0, halt_o = 0.
- c1_instr_addr_i = 0x44 vs c0 0x40 at one edge, c0_pc_i = 0x3C -> error_o pulses the next cycle; 2 DRAIN cycles follow; then 31 writes with rf_waddr_o 1..31 and rf_wdata_o equal to core 0's register-file contents (xN preloaded with 0x1000+N); then pc_restore_valid_o with pc_restore_o = 0x3C; err_count_o = 1; halt_o high for exactly 35 cycles.
- Both data_req high, both we = 0, data_wdata differs (0xAAAA vs 0x5555) -> no error. Same stimulus with both we = 1 -> error detected.
- Mismatch injected during RESTORE at index 10 -> ignored; the restore completes through index 31 and err_count_o stays at 1.
- 10 separate mismatches with MAX_ERRORS = 10 -> the 10th enters FATAL: error_o pulses once, fatal_o = 1 and halt_o = 1 held until rst_ni is pulsed; no register-file writes after the 10th.
- rst_ni asserted at RESTORE index 5 -> rf_we_o, halt_o and err_count_o are 0 in the same cycle; after release the state is RUN and no restore resumes.
